// File: rtl/gost_round_engine.sv
// gost_round_engine: iterative GOST 28147-89 / Magma 64-bit block cipher core.
// One Feistel round per clock by default. Defining GOST_ENGINE_UNROLL2_EN chains
// two rounds per clock (two subst instances), with results bit-identical to the
// default build. ZEROIZE=1 clears key, data state and result on handoff.

// Magma S-box layer: nibble i of the word goes through permutation row i.
module subst (
    input  logic [31:0] data_i,
    output logic [31:0] data_c_o
);
    // Row i holds pi_i; entry v sits at bits [4v+3:4v].
    localparam logic [63:0] SBOX [8] = '{
        64'h1F307D8E9B5A264C,
        64'hF0DB74E1C5A93286,
        64'h069C471EDAF2853B,
        64'hB9E35A076F4D128C,
        64'hC24BE390D618A5F7,
        64'h0E34187BAC296FD5,
        64'h73AD0B4FC19652E8,
        64'h2BC96AF43850DE71
    };

    // Per-nibble table lookup
    always_comb begin
        logic [63:0] row;
        data_c_o = '0;
        row      = '0;
        for (int i = 0; i < 8; i++) begin
            row                  = SBOX[3'(i)];
            data_c_o[4*i +: 4]   = row[{data_i[4*i +: 4], 2'b00} +: 4];
        end
    end
endmodule

module gost_round_engine #(
    parameter bit ZEROIZE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [255:0] in_key,
    input  logic         in_decrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    logic [255:0]        key_q, key_d;
    logic                dec_q, dec_d;
    logic [WORD_W-1:0]   n1_q, n1_d, n2_q, n2_d;
    logic [63:0]         out_data_q, out_data_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [WORD_W-1:0]   n1_rnd, n2_rnd;
    logic                last_rnd;

    function automatic logic [WORD_W-1:0] rol11(input logic [WORD_W-1:0] x);
        return {x[20:0], x[31:21]};
    endfunction

    // Subkey for a round: K_i lives at key[255-32*i -: 32]; the tail rounds
    // (last 8 for encrypt, last 24 for decrypt) walk the key words backwards.
    function automatic logic [WORD_W-1:0] round_key(input logic [255:0]    key,
                                                    input logic [RND_W-1:0] rnd,
                                                    input logic            dec);
        logic       fwd;
        logic [2:0] idx;
        fwd = dec ? (rnd < 5'd8) : (rnd < 5'd24);
        idx = fwd ? rnd[2:0] : ~rnd[2:0];
        return key[{~idx, 5'b00000} +: 32];
    endfunction

    logic [WORD_W-1:0] sum0, sub0, t0;

    // First (or only) round of this clock
    assign sum0 = n1_q + round_key(key_q, rnd_q, dec_q);
    subst u_subst0 (.data_i(sum0), .data_c_o(sub0));
    assign t0   = rol11(sub0);

`ifdef GOST_ENGINE_UNROLL2_EN
    localparam logic [RND_W-1:0] RND_STEP = 5'd2;
    localparam logic [RND_W-1:0] RND_LAST = 5'd30;

    logic [WORD_W-1:0] n1_mid, sum1, sub1, t1;

    // Second chained round on the odd round index
    assign n1_mid = n2_q ^ t0;
    assign sum1   = n1_mid + round_key(key_q, {rnd_q[4:1], 1'b1}, dec_q);
    subst u_subst1 (.data_i(sum1), .data_c_o(sub1));
    assign t1     = rol11(sub1);
    assign n1_rnd = n1_q ^ t1;
    assign n2_rnd = n1_mid;
`else
    localparam logic [RND_W-1:0] RND_STEP = 5'd1;
    localparam logic [RND_W-1:0] RND_LAST = 5'd31;

    assign n1_rnd = n2_q ^ t0;
    assign n2_rnd = n1_q;
`endif

    assign last_rnd = (rnd_q == RND_LAST);

    // Next-state, datapath load and registered-output decode
    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        key_d      = key_q;
        dec_d      = dec_q;
        n1_d       = n1_q;
        n2_d       = n2_q;
        out_data_d = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = S_RUN;
                    key_d   = in_key;
                    dec_d   = in_decrypt;
                    n1_d    = in_data[31:0];
                    n2_d    = in_data[63:32];
                    rnd_d   = '0;
                end
            end
            S_RUN: begin
                n1_d  = n1_rnd;
                n2_d  = n2_rnd;
                rnd_d = rnd_q + RND_STEP;
                if (last_rnd) begin
                    state_d    = S_DONE;
                    out_data_d = {n1_rnd, n2_rnd};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (ZEROIZE) begin
                        key_d      = '0;
                        n1_d       = '0;
                        n2_d       = '0;
                        out_data_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rnd_q       <= '0;
            key_q       <= '0;
            dec_q       <= 1'b0;
            n1_q        <= '0;
            n2_q        <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            key_q       <= key_d;
            dec_q       <= dec_d;
            n1_q        <= n1_d;
            n2_q        <= n2_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gost_round_engine.sv
// Directed bench for gost_round_engine using the Magma reference vectors.
// Two instances share stimulus: dut (ZEROIZE=1) and dut_nz (ZEROIZE=0).
module tb_gost_round_engine;
`ifdef GOST_ENGINE_UNROLL2_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif
    localparam int PERIOD = LAT + 1;

    localparam logic [255:0] KEY =
        256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0] PT = 64'hfedcba9876543210;
    localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [63:0]  in_data;
    logic [255:0] in_key;
    logic         in_decrypt;
    logic         out_ready;

    logic         in_ready, out_valid, busy;
    logic [63:0]  out_data;
    logic         nz_in_ready, nz_out_valid, nz_busy;
    logic [63:0]  nz_out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gost_round_engine #(.ZEROIZE(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    gost_round_engine #(.ZEROIZE(1'b0)) dut_nz (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (nz_in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (nz_out_valid),
        .out_ready  (out_ready),
        .out_data   (nz_out_data),
        .busy       (nz_busy)
    );

    // Present one block while idle, then count edges until out_valid (accept edge = 1).
    task automatic run_block(input logic [63:0] d, input logic dec,
                             output logic [63:0] res, output int lat);
        lat        = -1;
        res        = '0;
        in_data    = d;
        in_decrypt = dec;
        in_key     = KEY;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_data    = ~d;
        in_key     = ~KEY;
        in_decrypt = ~dec;
        for (int n = 2; n <= 100; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                res = out_data;
                break;
            end
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_data    = '0;
        in_key     = '0;
        in_decrypt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL reset_flags: got %b want 010", {out_valid, in_ready, busy});
        end
        total++;
        if (out_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        total++;
        if ({nz_out_valid, nz_in_ready, nz_busy} !== 3'b010) begin
            bad++;
            $display("FAIL reset_flags_nz: got %b want 010", {nz_out_valid, nz_in_ready, nz_busy});
        end
        total++;
        if (nz_out_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_data_nz: got %h want 0", nz_out_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL reset_release_idle: got %b want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_encrypt();
        logic [63:0] res;
        int          lat;
        run_block(PT, 1'b0, res, lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL enc_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (res !== CT) begin
            bad++;
            $display("FAIL enc_data: got %h want %h", res, CT);
        end
        total++;
        if (nz_out_data !== CT) begin
            bad++;
            $display("FAIL enc_data_nz: got %h want %h", nz_out_data, CT);
        end
        total++;
        if ({in_ready, busy} !== 2'b00) begin
            bad++;
            $display("FAIL enc_done_flags: got %b want 00", {in_ready, busy});
        end
        handoff();
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL enc_handoff_flags: got %b want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_decrypt();
        logic [63:0] res;
        int          lat;
        run_block(CT, 1'b1, res, lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL dec_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (res !== PT) begin
            bad++;
            $display("FAIL dec_data: got %h want %h", res, PT);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        logic [63:0] res;
        int          lat;
        run_block(PT, 1'b0, res, lat);
        total++;
        if (res !== CT) begin
            bad++;
            $display("FAIL bp_first_data: got %h want %h", res, CT);
        end
        in_data    = CT;
        in_decrypt = 1'b1;
        in_key     = KEY;
        in_valid   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, busy, out_data} !== {3'b100, CT}) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: got v/r/b=%b data=%h want 100 %h",
                         c, {out_valid, in_ready, busy}, out_data, CT);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL bp_handoff_no_accept: got %b want 010", {out_valid, in_ready, busy});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if ({in_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL bp_accept_next_edge: got %b want 01", {in_ready, busy});
        end
        lat = -1;
        res = '0;
        for (int n = 2; n <= 100; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                res = out_data;
                break;
            end
        end
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL bp_second_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (res !== PT) begin
            bad++;
            $display("FAIL bp_second_data: got %h want %h", res, PT);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        logic [63:0] blk  [4];
        logic [63:0] expv [4];
        logic [63:0] res  [4];
        int          acc  [4];
        logic [3:0]  decv;
        logic        prev_busy;
        int          k;
        int          r;
        blk  = '{PT, CT, PT, CT};
        expv = '{CT, PT, CT, PT};
        res  = '{64'h0, 64'h0, 64'h0, 64'h0};
        acc  = '{-1000, -1000, -1000, -1000};
        decv = 4'b1010;
        k    = 0;
        r    = 0;
        out_ready  = 1'b1;
        in_key     = KEY;
        in_data    = blk[0];
        in_decrypt = decv[0];
        in_valid   = 1'b1;
        prev_busy  = busy;
        for (int c = 1; c <= 8 * PERIOD && r < 4; c++) begin
            @(posedge clk); #1;
            if (busy && !prev_busy && k < 4) begin
                acc[k] = c;
                k++;
                if (k < 4) begin
                    in_data    = blk[k];
                    in_decrypt = decv[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            prev_busy = busy;
            if (out_valid && r < 4) begin
                res[r] = out_data;
                r++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (r !== 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d results want 4", r);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (res[i] !== expv[i]) begin
                bad++;
                $display("FAIL b2b_data[%0d]: got %h want %h", i, res[i], expv[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (acc[i] - acc[i-1] !== PERIOD) begin
                bad++;
                $display("FAIL b2b_period[%0d]: got %0d want %0d", i, acc[i] - acc[i-1], PERIOD);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] res;
        int          lat;
        in_data    = PT;
        in_decrypt = 1'b0;
        in_key     = KEY;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL midrst_flags: got %b want 010", {out_valid, in_ready, busy});
        end
        total++;
        if (nz_out_data !== 64'h0) begin
            bad++;
            $display("FAIL midrst_data_nz: got %h want 0", nz_out_data);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(PT, 1'b0, res, lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL midrst_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (res !== CT) begin
            bad++;
            $display("FAIL midrst_data: got %h want %h", res, CT);
        end
        handoff();
    endtask

    task automatic test_zeroize();
        logic [63:0] res;
        int          lat;
        run_block(PT, 1'b0, res, lat);
        total++;
        if (res !== CT) begin
            bad++;
            $display("FAIL zero_pre_data: got %h want %h", res, CT);
        end
        handoff();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_data !== 64'h0) begin
            bad++;
            $display("FAIL zero_cleared: got %h want 0", out_data);
        end
        total++;
        if (nz_out_data !== CT) begin
            bad++;
            $display("FAIL zero_retained_nz: got %h want %h", nz_out_data, CT);
        end
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL zero_idle_flags: got %b want 010", {out_valid, in_ready, busy});
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_zeroize();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gost_round_engine.md
Name: gost_round_engine

Overview:
- Iterative GOST 28147-89 / Magma 64-bit block cipher core. It computes one Feistel round per clock: a modular key add, then the `subst` S-box stage, then a rotate-left by 11, then an XOR.
- The block sits directly upstream of `subst` and consumes its output. It owns the round sequencing, the key schedule and the data handshake around it.
- It takes a 64-bit block and a 256-bit key. After 32 rounds it returns the encrypted or decrypted block.

Parameters:
- ZEROIZE, 1. When 1, the key register, data state and out_data are cleared on the DONE->IDLE transition. When 0, they keep their values.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block/key present.
- in_ready  out  1  engine can accept; high only in IDLE.
- in_data  in  64  plaintext or ciphertext block.
- in_key  in  256  key; K_i = in_key[255-32*i -: 32], i=0..7.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- out_valid  out  1  result available.
- out_ready  in  1  downstream takes result.
- out_data  out  64  result block.
- busy  out  1  high in RUN.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, round counter=0, key/state registers=0. An assertion of rst_n mid-RUN or mid-DONE aborts immediately; the partial result is discarded.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready on an edge, latch key and mode, load n1=in_data[31:0] and n2=in_data[63:32], set rnd=0, go to RUN.
  - RUN: on each edge, t = rol11(subst(n1 + K_sel) mod 2^32); n2<=n1; n1<=n2^t; rnd<=rnd+1. When rnd==31, also go to DONE.
  - DONE: out_valid=1, out_data={n1,n2}, i.e. high word = last computed word, with the final-round swap undone. Hold stable until out_ready. On out_valid&out_ready, go to IDLE.
- Key select, with rnd in 0..31:
  - Encrypt: index = rnd[2:0] for rnd<24; 7-rnd[2:0] for rnd>=24.
  - Decrypt: index = rnd[2:0] for rnd<8; 7-rnd[2:0] for rnd>=8.
- Arithmetic: the add is 32-bit with the carry discarded. The rotate is a 32-bit circular rotate-left by 11.
- Latency: out_valid rises on the 33rd rising edge, counting the accept edge as edge 1. Peak throughput is one block per 34 cycles (accept, 32 rounds, handoff).
- Handshake:
  - in_valid is ignored outside IDLE.
  - in_data, in_key and in_decrypt need only be stable on the accept edge.
  - A new block cannot be accepted in the same cycle as DONE->IDLE; the earliest accept is the following edge.
- Backpressure: DONE holds indefinitely while out_ready=0. out_data must not change while out_valid=1.
- ZEROIZE=1: out_data reads 0 in IDLE after a handoff.

Optional Feature:
- Macro: GOST_ENGINE_UNROLL2_EN.
- When defined: two chained rounds are computed per edge using two `subst` instances. rnd advances by 2 per edge and DONE is entered when rnd==30 before the increment. out_valid rises on the 17th edge after accept. Results are bit-identical to the single-round build.
- When undefined: one round per edge as above, with a single `subst` instance.

Test Plan:
- Encrypt:
  - Stimulus: key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, in_data fedcba9876543210, in_decrypt=0.
  - Required: out_data 4ee901e5c2d8ca3d, out_valid high exactly 33 edges after accept (17 with UNROLL2).
- Decrypt:
  - Stimulus: same key, in_data 4ee901e5c2d8ca3d, in_decrypt=1.
  - Required: out_data fedcba9876543210.
- Backpressure and input blocking:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; keep in_valid=1 with a different block throughout.
  - Required: out_data stable at 4ee901e5c2d8ca3d; in_ready=0 and no new accept until one cycle after the handoff.
- Back-to-back:
  - Stimulus: 4 blocks alternating encrypt/decrypt with the same key, out_ready=1.
  - Required: results match the vectors above; blocks accepted every 34 cycles.
- Reset mid-RUN:
  - Stimulus: deassert rst_n at round 10.
  - Required: out_valid=0, in_ready=1, busy=0 immediately. A following encrypt of the same vector still yields 4ee901e5c2d8ca3d.
- Zeroize:
  - Stimulus: ZEROIZE=1, after a handoff.
  - Required: out_data=0 in IDLE. With ZEROIZE=0, out_data retains 4ee901e5c2d8ca3d.
